dm_loader: RTL and testbench

Upstream loader for the single-core data memory. Accepts a byte stream (from the UART receiver) over a valid/ready handshake and assembles a length header plus 12-bit data words. It writes the words into data memory at consecutive addresses, then raises `start_writing` so the data memory / core stage begins working on the loaded matrix set.

---
 rtl/dm_loader.sv | 82 ++++++++
 tb/tb_dm_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dm_loader.sv
// dm_loader: assembles a length-prefixed byte stream into data-memory word writes,
// then raises start_writing so the downstream core stage can use the loaded set.
module dm_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start_writing,
    output logic              load_done,
    output logic              busy,
    output logic              err_len
);
    typedef enum logic [2:0] {IDLE, HDR_HI, DATA_LO, DATA_HI, WRITE, DONE} state_t;
    localparam logic [11:0] MAX_CNT = 12'(MAX_WORDS);
    state_t      state, state_d;
    logic [7:0]  cnt_lo, data_lo;
    logic [11:0] count, idx, hdr_count;
    logic [15:0] word;
    logic        accept;
    assign accept    = rx_valid && rx_ready;
    assign hdr_count = {rx_data[3:0], cnt_lo};
    assign word      = {rx_data, data_lo};
    assign rx_ready  = state inside {IDLE, HDR_HI, DATA_LO, DATA_HI};
    assign mem_we    = state == WRITE;
    assign load_done = state == DONE;
    assign busy      = state inside {HDR_HI, DATA_LO, DATA_HI, WRITE};
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? HDR_HI : IDLE;
            HDR_HI:  if (accept) state_d = (hdr_count == 12'd0) ? DONE :
                                           (hdr_count > MAX_CNT) ? IDLE : DATA_LO;
            DATA_LO: state_d = accept ? DATA_HI : DATA_LO;
            DATA_HI: state_d = accept ? WRITE : DATA_HI;
            WRITE:   state_d = (idx == count - 12'd1) ? DONE : DATA_LO;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt_lo        <= '0;
            data_lo       <= '0;
            count         <= '0;
            idx           <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            start_writing <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && accept) begin
                cnt_lo        <= rx_data;
                start_writing <= 1'b0;
                err_len       <= 1'b0;
            end
            if (state == HDR_HI && accept) begin
                count <= hdr_count;
                idx   <= '0;
                if (hdr_count > MAX_CNT) err_len <= 1'b1;
            end
            if (state == DATA_LO && accept) data_lo <= rx_data;
            // address and data are registered here so they are stable throughout WRITE
            if (state == DATA_HI && accept) begin
                mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                mem_wdata <= DATA_W'(word);
            end
            if (state == WRITE) idx <= idx + 12'd1;
            if (state_d == DONE) start_writing <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dm_loader.sv
// tb_dm_loader: randomized frame stimulus checked against a queue-based model of the loader.
module tb_dm_loader;
    localparam int MAXW = 64;
    logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, mem_we, start_writing, load_done, busy, err_len;
    logic [11:0] mem_addr, mem_wdata;
    int          tests = 0, fails = 0, cyc = 0, ld_cnt = 0, ld_cyc = 0, t0 = 0;
    bit          to_err = 0;
    logic [23:0] got[$], exp_q[$];
    logic [7:0]  fr[$];

    dm_loader dut (.clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
                   .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
                   .mem_wdata(mem_wdata), .start_writing(start_writing),
                   .load_done(load_done), .busy(busy), .err_len(err_len));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n) begin
        if (mem_we) got.push_back({mem_addr, mem_wdata});
        if (load_done) begin ld_cnt++; ld_cyc = cyc; end
    end
    initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    task automatic send_byte(input logic [7:0] b, input bit tog, input bit first);
        int n = 0;
        if (tog) begin rx_valid = 1'b0; rx_data = 8'hEE; @(negedge clk); end
        rx_valid = 1'b1; rx_data = b;
        while (!rx_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to_err = 1;
        else begin @(negedge clk); if (first) t0 = cyc; end
    endtask

    task automatic build(input int cnt, input logic [3:0] hi_extra);
        logic [15:0] w;
        fr.delete(); exp_q.delete();
        fr.push_back(8'(cnt)); fr.push_back({hi_extra, 4'(cnt >> 8)});
        if (cnt <= MAXW) for (int i = 0; i < cnt; i++) begin
            w = 16'($urandom);
            fr.push_back(w[7:0]); fr.push_back(w[15:8]);
            exp_q.push_back({12'(i), w[11:0]});
        end
    endtask

    task automatic run(input bit tog);
        got.delete(); ld_cnt = 0; to_err = 0;
        foreach (fr[i]) send_byte(fr[i], tog, i == 0);
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, start_writing, load_done, busy, err_len} !== {1'b1, 1'b0, 24'd0, 4'b0}) begin
            fails++; $display("FAIL reset_outputs got %b", {rx_ready, mem_we, mem_addr, mem_wdata, start_writing, load_done, busy, err_len});
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_fixed(input bit tog);
        fr = '{8'h04, 8'h00, 8'h23, 8'h01, 8'h56, 8'h04, 8'h89, 8'h07, 8'hBC, 8'h0A};
        exp_q = '{{12'd0, 12'h123}, {12'd1, 12'h456}, {12'd2, 12'h789}, {12'd3, 12'hABC}};
        run(tog);
        tests++; if (to_err) begin fails++; $display("FAIL fixed_accept timeout tog=%0d", tog); end
        tests++; if (got.size() != 4) begin fails++; $display("FAIL fixed_nwrites got %0d want 4", got.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL fixed_write[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        tests++; if (ld_cnt != 1) begin fails++; $display("FAIL fixed_load_done count %0d want 1", ld_cnt); end
        if (!tog) begin
            tests++; if (ld_cyc != t0 + 13) begin fails++; $display("FAIL fixed_ld_timing got %0d want %0d", ld_cyc - t0, 13); end
        end
        tests++; if ({start_writing, busy, err_len} !== 3'b100) begin fails++; $display("FAIL fixed_flags got %b want 100", {start_writing, busy, err_len}); end
    endtask

    task automatic test_zero();
        build(0, 4'h0); run(0);
        tests++; if (got.size() != 0) begin fails++; $display("FAIL zero_writes got %0d want 0", got.size()); end
        tests++; if (ld_cnt != 1 || ld_cyc != t0 + 1) begin fails++; $display("FAIL zero_load_done cnt %0d at +%0d want 1 at +1", ld_cnt, ld_cyc - t0); end
        tests++; if (start_writing !== 1'b1) begin fails++; $display("FAIL zero_start_writing got %b want 1", start_writing); end
    endtask

    task automatic test_err_len();
        got.delete(); ld_cnt = 0; to_err = 0;
        send_byte(8'h41, 0, 1); send_byte(8'h00, 0, 0); rx_valid = 1'b0;
        tests++; if ({err_len, busy, rx_ready} !== 3'b101) begin fails++; $display("FAIL err_abort got err/busy/ready %b want 101", {err_len, busy, rx_ready}); end
        repeat (6) @(negedge clk);
        tests++; if (got.size() != 0 || ld_cnt != 0 || start_writing !== 1'b0 || err_len !== 1'b1) begin
            fails++; $display("FAIL err_effects writes %0d ld %0d sw %b err %b want 0 0 0 1", got.size(), ld_cnt, start_writing, err_len);
        end
        got.delete();
        send_byte(8'h01, 0, 1);
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err_len); end
        send_byte(8'h00, 0, 0); send_byte(8'hF3, 0, 0); send_byte(8'hFF, 0, 0); rx_valid = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (got.size() != 1 || got[0] !== {12'd0, 12'hFF3}) begin fails++; $display("FAIL err_recover writes %0d first %h want 1 000ff3", got.size(), got.size() ? got[0] : 24'h0); end
    endtask

    task automatic test_random();
        int cnt;
        for (int k = 0; k < 10; k++) begin
            cnt = (k == 0) ? MAXW : (k == 1) ? 1 : int'($urandom_range(0, MAXW));
            build(cnt, 4'($urandom)); run(k[0]);
            tests++; if (to_err) begin fails++; $display("FAIL rand%0d accept timeout", k); end
            tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_nwrites got %0d want %0d", k, got.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got.size()) begin
                tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_write[%0d] got %h want %h", k, i, got[i], exp_q[i]); end
            end
            tests++; if (ld_cnt != 1 || (!k[0] && ld_cyc != t0 + 3 * cnt + 1)) begin
                fails++; $display("FAIL rand%0d_load_done cnt %0d at +%0d want 1 at +%0d", k, ld_cnt, ld_cyc - t0, 3 * cnt + 1);
            end
            tests++; if ({start_writing, err_len} !== 2'b10) begin fails++; $display("FAIL rand%0d_flags got %b want 10", k, {start_writing, err_len}); end
        end
        build(MAXW + 1 + int'($urandom_range(0, 3000)), 4'($urandom)); run(0);
        tests++; if (got.size() != 0 || ld_cnt != 0 || {start_writing, err_len} !== 2'b01) begin
            fails++; $display("FAIL rand_oversize writes %0d ld %0d sw/err %b want 0 0 01", got.size(), ld_cnt, {start_writing, err_len});
        end
    endtask

    task automatic test_back_to_back();
        build(3, 4'h0); run(0);
        build(2, 4'h5);
        got.delete(); ld_cnt = 0;
        send_byte(fr[0], 0, 1);
        tests++; if ({start_writing, busy} !== 2'b01) begin fails++; $display("FAIL b2b_drop sw/busy %b want 01", {start_writing, busy}); end
        for (int i = 1; i < fr.size(); i++) send_byte(fr[i], 0, 0);
        rx_valid = 1'b0; repeat (6) @(negedge clk);
        tests++; if (start_writing !== 1'b1 || ld_cnt != 1) begin fails++; $display("FAIL b2b_rise sw %b ld %0d want 1 1", start_writing, ld_cnt); end
        tests++; if (got.size() != 2 || got[0] !== exp_q[0] || got[1] !== exp_q[1]) begin fails++; $display("FAIL b2b_writes n %0d want 2", got.size()); end
    endtask

    task automatic test_reset_mid();
        fr = '{8'h04, 8'h00, 8'h5A};
        got.delete(); ld_cnt = 0;
        foreach (fr[i]) send_byte(fr[i], 0, i == 0);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0; #1;
        tests++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, start_writing, load_done, busy, err_len} !== {1'b1, 1'b0, 24'd0, 4'b0}) begin
            fails++; $display("FAIL midreset_outputs got %b", {rx_ready, mem_we, mem_addr, mem_wdata, start_writing, load_done, busy, err_len});
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        tests++; if (got.size() != 0 || ld_cnt != 0) begin fails++; $display("FAIL midreset_nowrite writes %0d ld %0d want 0 0", got.size(), ld_cnt); end
        build(3, 4'h0); run(0);
        tests++; if (got.size() != 3 || got[0] !== exp_q[0] || got[2] !== exp_q[2] || ld_cnt != 1) begin
            fails++; $display("FAIL midreset_fresh writes %0d ld %0d want 3 1", got.size(), ld_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fixed(0);
        test_fixed(1);
        test_zero();
        test_err_len();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
